uart_echo_responder: RTL

Far-end responder for the UART link: consumes bytes delivered by the receive side of `uart_top_level` (`rx_data`/`rx_ready`/`rx_error`) and retransmits each one through the transmit side (`tx_data`/`tx_start`, tracking `tx_busy`/`tx_done`). It sits between the two halves of a `uart_top_level` instance and buffers received bytes in a FIFO so that back-to-back reception never waits on transmission. It also keeps error and overflow statistics, and applies an optional XOR transform so a bench can tell echoed bytes from looped-back bytes.

---
 rtl/uart_echo_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_echo_responder.sv
// rtl/uart_echo_responder.sv - buffered UART echo with XOR transform and error/overflow statistics
// Received bytes are queued in a FIFO and replayed one at a time through the transmitter handshake.
module uart_echo_responder #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [7:0]  XOR_MASK   = 8'h00
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  rx_data,
   input  logic                        rx_ready,
   input  logic                        rx_error,
   output logic [7:0]                  tx_data,
   output logic                        tx_start,
   input  logic                        tx_busy,
   input  logic                        tx_done,
   input  logic                        echo_en,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   output logic [7:0]                  drop_cnt,
   output logic [7:0]                  err_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_start_q, tx_start_d;
   logic            overflow_q, overflow_d;
   logic [7:0]      drop_cnt_q, drop_cnt_d;
   logic [7:0]      err_cnt_q, err_cnt_d;

   logic            fifo_full;
   logic            pop;
   logic            push;
   logic            drop;
   logic            rx_bad;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   always_comb begin
      fifo_full = (count_q == FULL_COUNT);
      pop       = (state_q == IDLE) && echo_en && (count_q != '0);
      rx_bad    = rx_ready && rx_error;
      push      = rx_ready && !rx_error && (!fifo_full || pop);
      drop      = rx_ready && !rx_error && fifo_full && !pop;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_comb begin
      overflow_d = overflow_q | drop;
      drop_cnt_d = drop_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
      if (rx_bad && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_comb begin
      state_d    = state_q;
      tx_start_d = tx_start_q;
      tx_data_d  = tx_data_q;
      case (state_q)
         IDLE: begin
            tx_start_d = 1'b0;
            if (pop) begin
               state_d    = START;
               tx_start_d = 1'b1;
               tx_data_d  = mem_q[rd_ptr_q] ^ XOR_MASK;
            end
         end
         START: begin
            tx_start_d = 1'b1;
            if (tx_busy) begin
               state_d    = WAIT_DONE;
               tx_start_d = 1'b0;
            end
         end
         WAIT_DONE: begin
            tx_start_d = 1'b0;
            if (tx_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d    = IDLE;
            tx_start_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'h00;
         err_cnt_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // Storage needs no reset: entries are only read once count_q says they were written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= rx_data;
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_start   = tx_start_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign drop_cnt   = drop_cnt_q;
   assign err_cnt    = err_cnt_q;

endmodule
